// File: rtl/uart_ctrl_pkg.sv
// rtl/uart_ctrl_pkg.sv - register map, bit positions and TX state encoding for uart_ctrl
package uart_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_RXCNT  = 2'd3;

  localparam int ST_RX_AVAIL   = 0;
  localparam int ST_RX_FULL    = 1;
  localparam int ST_TX_EMPTY   = 2;
  localparam int ST_TX_FULL    = 3;
  localparam int ST_RX_OVERRUN = 4;
  localparam int ST_TX_BUSY    = 5;

  localparam int CTRL_RX_IRQ_EN       = 0;
  localparam int CTRL_TX_EMPTY_IRQ_EN = 1;
  localparam int CTRL_CLR_OVERRUN     = 7;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_t;

endpackage

// File: rtl/uart_ctrl_fifo.sv
// rtl/uart_ctrl_fifo.sv - first-word-fall-through FIFO with simultaneous push/pop
module uart_ctrl_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign head    = mem[rptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_ctrl.sv
// rtl/uart_ctrl.sv - CPU-bus register front end that buffers and sequences bytes for the UART core
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] bus_addr,
  input  logic       bus_wr,
  input  logic       bus_rd,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       bus_rdata_valid,
  output logic       irq,
  output logic [7:0] u_tx_data,
  output logic       u_tx_data_valid,
  input  logic       u_tx_data_ack,
  input  logic [7:0] u_rx_data,
  input  logic       u_rx_data_fresh
);
  localparam int TXC = $clog2(TX_DEPTH) + 1;
  localparam int RXC = $clog2(RX_DEPTH) + 1;

  tx_state_t      tx_state;
  logic           rx_irq_en;
  logic           tx_empty_irq_en;
  logic           rx_overrun;

  logic           tx_push;
  logic           tx_pop;
  logic           tx_full;
  logic           tx_empty;
  logic [7:0]     tx_head;
  logic [TXC-1:0] tx_count;

  logic           rx_pop;
  logic           rx_full;
  logic           rx_empty;
  logic           rx_drop;
  logic [7:0]     rx_head;
  logic [RXC-1:0] rx_count;

  logic           tx_busy;
  logic [7:0]     status;
  logic [7:0]     rd_mux;

  assign tx_busy = (tx_state != TX_IDLE);
  assign tx_push = bus_wr && (bus_addr == ADDR_DATA);
  assign tx_pop  = (tx_state == TX_SEND) && u_tx_data_ack;
  assign rx_pop  = bus_rd && (bus_addr == ADDR_DATA);
  // A byte arriving into a full RX FIFO survives only if a DATA read frees a slot that cycle.
  assign rx_drop = u_rx_data_fresh && rx_full && !rx_pop;

  uart_ctrl_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (bus_wdata),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  uart_ctrl_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (u_rx_data_fresh),
    .push_data (u_rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  always_comb begin
    status                = '0;
    status[ST_RX_AVAIL]   = !rx_empty;
    status[ST_RX_FULL]    = rx_full;
    status[ST_TX_EMPTY]   = tx_empty;
    status[ST_TX_FULL]    = tx_full;
    status[ST_RX_OVERRUN] = rx_overrun;
    status[ST_TX_BUSY]    = tx_busy;
  end

  always_comb begin
    rd_mux = '0;
    case (bus_addr)
      ADDR_DATA:   rd_mux = rx_empty ? 8'h00 : rx_head;
      ADDR_STATUS: rd_mux = status;
      ADDR_CTRL: begin
        rd_mux[CTRL_RX_IRQ_EN]       = rx_irq_en;
        rd_mux[CTRL_TX_EMPTY_IRQ_EN] = tx_empty_irq_en;
      end
      default:     rd_mux = 8'(rx_count);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_rdata       <= '0;
      bus_rdata_valid <= 1'b0;
      irq             <= 1'b0;
      rx_irq_en       <= 1'b0;
      tx_empty_irq_en <= 1'b0;
      rx_overrun      <= 1'b0;
    end else begin
      bus_rdata_valid <= bus_rd;
      if (bus_rd) bus_rdata <= rd_mux;
      if (bus_wr && (bus_addr == ADDR_CTRL)) begin
        rx_irq_en       <= bus_wdata[CTRL_RX_IRQ_EN];
        tx_empty_irq_en <= bus_wdata[CTRL_TX_EMPTY_IRQ_EN];
        if (bus_wdata[CTRL_CLR_OVERRUN]) rx_overrun <= 1'b0;
      end
      // A new overrun wins over a clear written in the same cycle.
      if (rx_drop) rx_overrun <= 1'b1;
      irq <= (rx_irq_en && !rx_empty) ||
             (tx_empty_irq_en && tx_empty && !tx_busy) ||
             rx_overrun;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state        <= TX_IDLE;
      u_tx_data       <= '0;
      u_tx_data_valid <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_count != '0) begin
            u_tx_data       <= tx_head;
            u_tx_data_valid <= 1'b1;
            tx_state        <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (u_tx_data_ack) begin
            u_tx_data_valid <= 1'b0;
            tx_state        <= TX_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// tb/tb_uart_ctrl.sv - scoreboard bench for uart_ctrl with a queue-based reference model
module tb_uart_ctrl;
  localparam int TXD = 16;
  localparam int RXD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] bus_addr = '0;
  logic       bus_wr = 1'b0;
  logic       bus_rd = 1'b0;
  logic [7:0] bus_wdata = '0;
  logic [7:0] bus_rdata;
  logic       bus_rdata_valid;
  logic       irq;
  logic [7:0] u_tx_data;
  logic       u_tx_data_valid;
  logic       u_tx_data_ack = 1'b0;
  logic [7:0] u_rx_data = '0;
  logic       u_rx_data_fresh = 1'b0;

  uart_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus_addr        (bus_addr),
    .bus_wr          (bus_wr),
    .bus_rd          (bus_rd),
    .bus_wdata       (bus_wdata),
    .bus_rdata       (bus_rdata),
    .bus_rdata_valid (bus_rdata_valid),
    .irq             (irq),
    .u_tx_data       (u_tx_data),
    .u_tx_data_valid (u_tx_data_valid),
    .u_tx_data_ack   (u_tx_data_ack),
    .u_rx_data       (u_rx_data),
    .u_rx_data_fresh (u_rx_data_fresh)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  int         tx_cnt = 0;
  logic [7:0] sb_tx[$];
  logic [7:0] rx_q[$];
  logic [7:0] rd_exp[$];
  logic [1:0] m_ctrl = '0;
  logic       m_ovr = 1'b0;
  logic       irq_exp = 1'b0;
  logic       rd_due = 1'b0;

  logic       ack_hold = 1'b0;
  int         ack_wait = 0;
  logic       watch_ff = 1'b0;
  logic       saw_ff = 1'b0;
  logic       prev_v = 1'b0;
  logic [7:0] prev_d = '0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    logic       hs;
    logic       busy;
    logic       pop;
    logic [7:0] e;
    if (rst) begin
      tx_cnt  = 0;
      sb_tx.delete();
      rx_q.delete();
      m_ctrl  = '0;
      m_ovr   = 1'b0;
      irq_exp = 1'b0;
      rd_due  = 1'b0;
    end else begin
      hs   = u_tx_data_valid && u_tx_data_ack;
      busy = u_tx_data_valid;
      irq_exp = (m_ctrl[0] && rx_q.size() > 0) || (m_ctrl[1] && tx_cnt == 0 && !busy) || m_ovr;
      rd_due = bus_rd;
      if (bus_rd) begin
        case (bus_addr)
          2'd0:    e = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
          2'd1:    e = {2'b00, busy, m_ovr, tx_cnt == TXD, tx_cnt == 0, rx_q.size() == RXD, rx_q.size() > 0};
          2'd2:    e = {6'b0, m_ctrl};
          default: e = 8'(rx_q.size());
        endcase
        rd_exp.push_back(e);
      end
      if (bus_wr && bus_addr == 2'd0 && (tx_cnt < TXD || hs)) begin
        sb_tx.push_back(bus_wdata);
        tx_cnt++;
      end
      if (hs) tx_cnt--;
      if (bus_wr && bus_addr == 2'd2) begin
        m_ctrl = bus_wdata[1:0];
        if (bus_wdata[7]) m_ovr = 1'b0;
      end
      pop = bus_rd && bus_addr == 2'd0 && rx_q.size() > 0;
      if (u_rx_data_fresh && rx_q.size() == RXD && !pop) m_ovr = 1'b1;
      if (pop) void'(rx_q.pop_front());
      if (u_rx_data_fresh && rx_q.size() < RXD) rx_q.push_back(u_rx_data);
    end
  end

  // TX monitor: every handshake must carry the next accepted byte
  always @(posedge clk) begin
    if (!rst && u_tx_data_valid && u_tx_data_ack) begin
      if (watch_ff && u_tx_data == 8'hFF) saw_ff = 1'b1;
      if (sb_tx.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL tx_unexpected: got %02h, expected no byte", u_tx_data);
      end else begin
        chk("tx_byte", u_tx_data, sb_tx.pop_front());
      end
    end
  end

  // Bus/irq monitor
  always @(negedge clk) begin
    chk("rdata_valid", {7'b0, bus_rdata_valid}, {7'b0, rd_due});
    if (bus_rdata_valid) begin
      if (rd_exp.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rdata_unexpected: got %02h, expected no read", bus_rdata);
      end else begin
        chk("rdata", bus_rdata, rd_exp.pop_front());
      end
    end
    chk("irq", {7'b0, irq}, {7'b0, irq_exp});
    if (prev_v && u_tx_data_valid) chk("tx_hold", u_tx_data, prev_d);
    prev_v = u_tx_data_valid;
    prev_d = u_tx_data;
  end

  // UART core stand-in: acks after a random wait, plus stray acks while idle
  initial begin
    forever begin
      @(negedge clk);
      u_tx_data_ack = 1'b0;
      if (!rst && u_tx_data_valid && !ack_hold) begin
        if (ack_wait == 0) begin
          u_tx_data_ack = 1'b1;
          ack_wait = $urandom_range(0, 3);
        end else begin
          ack_wait--;
        end
      end else if (!u_tx_data_valid && $urandom_range(0, 7) == 0) begin
        u_tx_data_ack = 1'b1;
      end
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    bus_addr = a; bus_wdata = d; bus_wr = 1'b1;
    @(negedge clk);
    bus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    bus_addr = a; bus_rd = 1'b1;
    @(negedge clk);
    bus_rd = 1'b0;
    d = bus_rdata;
  endtask

  task automatic fresh(input logic [7:0] d);
    u_rx_data = d; u_rx_data_fresh = 1'b1;
    @(negedge clk);
    u_rx_data_fresh = 1'b0;
  endtask

  task automatic drain_tx();
    int n = 0;
    while ((tx_cnt != 0 || u_tx_data_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (n >= 1000) begin
      n_fail++;
      $display("FAIL tx_drain: got %0d bytes pending after timeout, expected 0", tx_cnt);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] b17[17];

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_valid", {7'b0, u_tx_data_valid}, 8'h00);
    chk("reset_txdata", u_tx_data, 8'h00);
    chk("reset_rdata", bus_rdata, 8'h00);
    chk("reset_irq", {7'b0, irq}, 8'h00);
    bus_read(2'd1, d);
    chk("reset_status", d, 8'h04);

    // two-byte send with handshake timing
    ack_hold = 1'b1;
    bus_write(2'd0, 8'h55);
    chk("t1_valid_early", {7'b0, u_tx_data_valid}, 8'h00);
    @(negedge clk);
    chk("t1_valid_rise", {7'b0, u_tx_data_valid}, 8'h01);
    chk("t1_data", u_tx_data, 8'h55);
    repeat (3) @(negedge clk);
    chk("t1_valid_held", {7'b0, u_tx_data_valid}, 8'h01);
    bus_write(2'd0, 8'hA3);
    ack_hold = 1'b0;
    drain_tx();
    @(negedge clk);
    bus_read(2'd1, d);
    chk("t1_status_empty", d, 8'h04);

    // TX full, 17th write dropped
    ack_hold = 1'b1;
    watch_ff = 1'b1;
    saw_ff = 1'b0;
    for (int i = 0; i < TXD; i++) bus_write(2'd0, 8'($urandom_range(0, 254)));
    bus_write(2'd0, 8'hFF);
    bus_read(2'd1, d);
    chk("t2_status_full", d, 8'h28);
    ack_hold = 1'b0;
    drain_tx();
    chk("t2_no_ff", {7'b0, saw_ff}, 8'h00);
    watch_ff = 1'b0;

    // basic RX
    fresh(8'h11); fresh(8'h22); fresh(8'h33);
    bus_read(2'd3, d); chk("t3_count3", d, 8'h03);
    bus_read(2'd0, d); chk("t3_rd0", d, 8'h11);
    bus_read(2'd0, d); chk("t3_rd1", d, 8'h22);
    bus_read(2'd0, d); chk("t3_rd2", d, 8'h33);
    bus_read(2'd0, d); chk("t3_rd_empty", d, 8'h00);
    bus_read(2'd3, d); chk("t3_count0", d, 8'h00);

    // overrun with rx irq enabled
    bus_write(2'd2, 8'h01);
    for (int i = 0; i < 17; i++) begin
      b17[i] = 8'($urandom);
      fresh(b17[i]);
    end
    bus_read(2'd1, d);
    chk("t4_status_ovr", d, 8'h17);
    chk("t4_irq", {7'b0, irq}, 8'h01);
    bus_write(2'd2, 8'h81);
    bus_read(2'd1, d);
    chk("t4_status_clr", d, 8'h07);
    chk("t4_irq_avail", {7'b0, irq}, 8'h01);

    // full RX with simultaneous fresh and DATA read
    u_rx_data = 8'hEE; u_rx_data_fresh = 1'b1;
    bus_addr = 2'd0; bus_rd = 1'b1;
    @(negedge clk);
    u_rx_data_fresh = 1'b0; bus_rd = 1'b0;
    chk("t5_oldest", bus_rdata, b17[0]);
    bus_read(2'd3, d); chk("t5_count16", d, 8'h10);
    bus_read(2'd1, d); chk("t5_no_ovr", d, 8'h07);
    for (int i = 0; i < RXD; i++) bus_read(2'd0, d);

    // reset while sending with bytes queued
    ack_hold = 1'b1;
    for (int i = 0; i < 5; i++) bus_write(2'd0, 8'($urandom));
    chk("t6_sending", {7'b0, u_tx_data_valid}, 8'h01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_valid_drop", {7'b0, u_tx_data_valid}, 8'h00);
    chk("t6_irq", {7'b0, irq}, 8'h00);
    bus_read(2'd1, d);
    chk("t6_status", d, 8'h04);
    ack_hold = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus_addr        = 2'($urandom_range(0, 3));
      bus_wdata       = 8'($urandom);
      bus_wr          = ($urandom_range(0, 3) == 0);
      bus_rd          = ($urandom_range(0, 2) == 0);
      u_rx_data       = 8'($urandom);
      u_rx_data_fresh = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    bus_wr = 1'b0; bus_rd = 1'b0; u_rx_data_fresh = 1'b0;
    drain_tx();
    repeat (3) @(negedge clk);
    chk("rd_queue_empty", 8'(rd_exp.size()), 8'h00);
    chk("tx_queue_empty", 8'(sb_tx.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
